// File: rtl/serial_port_responder.sv
// serial_port_responder
//
// Device-side endpoint of the processor's byte-wide serial IO interface. Bytes
// written by the processor are buffered in a TX FIFO and drained to a host-side
// valid/ready byte stream. Host bytes are buffered in an RX FIFO and presented
// to the processor for reading. Both FIFOs are first-word-fall-through.
//
// Ports:
//   clock, reset        system clock (rising edge), synchronous active-low reset
//   proc_data_out       RX FIFO head byte           (processor serial_in)
//   proc_valid_out      RX FIFO non-empty           (processor serial_valid_in)
//   proc_ready_out      TX FIFO not full            (processor serial_ready_in)
//   proc_data_in        byte from the processor     (processor serial_out)
//   proc_rden_in        pop RX head strobe          (processor serial_rden_out)
//   proc_wren_in        push proc_data_in strobe    (processor serial_wren_out)
//   host_rx_*           host -> processor byte stream (valid/ready)
//   host_tx_*           processor -> host byte stream (valid/ready)
//   rx_count, tx_count  FIFO occupancies, 0..DEPTH
//   overflow            sticky: write strobe while TX full
//   underflow           sticky: read strobe while RX empty
//   loopback_in         (SERIAL_LOOPBACK_EN only) route TX head into RX tail
//
// Build option: define SERIAL_LOOPBACK_EN to add loopback_in and the internal
// TX->RX loopback path. Without it the port and the path are absent.

module serial_port_responder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SERIAL_LOOPBACK_EN
  input  logic              loopback_in,
`endif
  output logic [7:0]        proc_data_out,
  output logic              proc_valid_out,
  output logic              proc_ready_out,
  input  logic [7:0]        proc_data_in,
  input  logic              proc_rden_in,
  input  logic              proc_wren_in,
  input  logic [7:0]        host_rx_data_in,
  input  logic              host_rx_valid_in,
  output logic              host_rx_ready_out,
  output logic [7:0]        host_tx_data_out,
  output logic              host_tx_valid_out,
  input  logic              host_tx_ready_in,
  output logic [ADDR_W:0]   rx_count,
  output logic [ADDR_W:0]   tx_count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0]   FullCnt = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CntOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne  = ADDR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  // Cleared by reset, set on the first edge after release. Every ready/valid is
  // qualified by it so all handshake outputs read 0 while reset is applied.
  logic activeQ;

  logic [7:0]        txMem [DEPTH];
  logic [7:0]        rxMem [DEPTH];
  logic [ADDR_W-1:0] txWrQ, txRdQ;
  logic [ADDR_W-1:0] rxWrQ, rxRdQ;
  logic [ADDR_W:0]   txCntQ, txCntD;
  logic [ADDR_W:0]   rxCntQ, rxCntD;
  logic              overflowQ, underflowQ;

  // ---------------------------------------------------------------------------
  // Status decode (registered counts only)
  // ---------------------------------------------------------------------------

  logic txEmpty, txFull, rxEmpty, rxFull;
  logic [7:0] txHead, rxHead;

  assign txEmpty = (txCntQ == '0);
  assign txFull  = (txCntQ == FullCnt);
  assign rxEmpty = (rxCntQ == '0);
  assign rxFull  = (rxCntQ == FullCnt);

  assign txHead = txMem[txRdQ];
  assign rxHead = rxMem[rxRdQ];

  // ---------------------------------------------------------------------------
  // Loopback routing
  // ---------------------------------------------------------------------------

  logic loopback;  // host side is disconnected while set
  logic lbMove;    // TX head transfers to RX tail this cycle

`ifdef SERIAL_LOOPBACK_EN
  assign loopback = loopback_in;
  assign lbMove   = activeQ & loopback_in & ~txEmpty & ~rxFull;
`else
  assign loopback = 1'b0;
  assign lbMove   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------

  assign proc_ready_out    = activeQ & ~txFull;
  assign proc_valid_out    = activeQ & ~rxEmpty;
  assign host_tx_valid_out = activeQ & ~txEmpty & ~loopback;
  assign host_rx_ready_out = activeQ & ~rxFull & ~loopback;

  // Head bytes are only meaningful with the matching valid; forcing 0 when
  // inactive keeps every output quiet during reset.
  assign proc_data_out    = activeQ ? rxHead : 8'h00;
  assign host_tx_data_out = activeQ ? txHead : 8'h00;

  assign tx_count  = txCntQ;
  assign rx_count  = rxCntQ;
  assign overflow  = overflowQ;
  assign underflow = underflowQ;

  // ---------------------------------------------------------------------------
  // Push / pop qualification
  // ---------------------------------------------------------------------------

  logic       txPush, txPop, rxPush, rxPop;
  logic [7:0] rxPushData;

  // A refused push (full) or refused pop (empty) never reaches the FIFO, so a
  // full FIFO with a pop only shrinks and an empty FIFO with a push only grows.
  assign txPush = proc_wren_in & proc_ready_out;
  assign txPop  = (host_tx_valid_out & host_tx_ready_in) | lbMove;
  assign rxPush = (host_rx_valid_in & host_rx_ready_out) | lbMove;
  assign rxPop  = proc_rden_in & proc_valid_out;

  // Host side is blocked during loopback, so the two RX sources never collide.
  assign rxPushData = lbMove ? txHead : host_rx_data_in;

  // ---------------------------------------------------------------------------
  // Occupancy next-state
  // ---------------------------------------------------------------------------

  always_comb begin
    txCntD = txCntQ;
    unique case ({txPush, txPop})
      2'b10:   txCntD = txCntQ + CntOne;
      2'b01:   txCntD = txCntQ - CntOne;
      default: txCntD = txCntQ;
    endcase
  end

  always_comb begin
    rxCntD = rxCntQ;
    unique case ({rxPush, rxPop})
      2'b10:   rxCntD = rxCntQ + CntOne;
      2'b01:   rxCntD = rxCntQ - CntOne;
      default: rxCntD = rxCntQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------

  always_ff @(posedge clock) begin
    if (!reset) begin
      activeQ    <= 1'b0;
      txWrQ      <= '0;
      txRdQ      <= '0;
      rxWrQ      <= '0;
      rxRdQ      <= '0;
      txCntQ     <= '0;
      rxCntQ     <= '0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      activeQ <= 1'b1;
      if (txPush) txWrQ <= txWrQ + PtrOne;
      if (txPop)  txRdQ <= txRdQ + PtrOne;
      if (rxPush) rxWrQ <= rxWrQ + PtrOne;
      if (rxPop)  rxRdQ <= rxRdQ + PtrOne;
      txCntQ <= txCntD;
      rxCntQ <= rxCntD;
      if (proc_wren_in && txFull)  overflowQ  <= 1'b1;
      if (proc_rden_in && rxEmpty) underflowQ <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (no reset; contents are qualified by the counts)
  // ---------------------------------------------------------------------------

  always_ff @(posedge clock) begin
    if (reset && txPush) txMem[txWrQ] <= proc_data_in;
    if (reset && rxPush) rxMem[rxWrQ] <= rxPushData;
  end

endmodule

// File: tb/tb_serial_port_responder.sv
// tb_serial_port_responder
//
// Directed bench for serial_port_responder. A queue-based reference model
// tracks both FIFOs and the sticky flags; one negedge process compares every
// handshake output, count and flag against it each cycle and then advances the
// model using the inputs that the next rising edge will sample. Directed
// sections add literal expectations for the byte streams seen by each side.
// Define SERIAL_LOOPBACK_EN for both files to include the loopback section.

module tb_serial_port_responder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        proc_data_out;
  logic              proc_valid_out;
  logic              proc_ready_out;
  logic [7:0]        proc_data_in;
  logic              proc_rden_in;
  logic              proc_wren_in;
  logic [7:0]        host_rx_data_in;
  logic              host_rx_valid_in;
  logic              host_rx_ready_out;
  logic [7:0]        host_tx_data_out;
  logic              host_tx_valid_out;
  logic              host_tx_ready_in;
  logic [ADDR_W:0]   rx_count;
  logic [ADDR_W:0]   tx_count;
  logic              overflow;
  logic              underflow;
  logic              lbIn;

  serial_port_responder #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
`ifdef SERIAL_LOOPBACK_EN
    .loopback_in      (lbIn),
`endif
    .proc_data_out    (proc_data_out),
    .proc_valid_out   (proc_valid_out),
    .proc_ready_out   (proc_ready_out),
    .proc_data_in     (proc_data_in),
    .proc_rden_in     (proc_rden_in),
    .proc_wren_in     (proc_wren_in),
    .host_rx_data_in  (host_rx_data_in),
    .host_rx_valid_in (host_rx_valid_in),
    .host_rx_ready_out(host_rx_ready_out),
    .host_tx_data_out (host_tx_data_out),
    .host_tx_valid_out(host_tx_valid_out),
    .host_tx_ready_in (host_tx_ready_in),
    .rx_count         (rx_count),
    .tx_count         (tx_count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO contents as queues, plus flags
  // ---------------------------------------------------------------------------

  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic [7:0] hostGot[$];   // bytes the host accepted
  logic [7:0] procGot[$];   // bytes the processor read
  bit         mActive = 1'b0;
  bit         mOvf    = 1'b0;
  bit         mUnf    = 1'b0;
  bit         sawHostTxValid = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      begin
        bit eProcReady, eProcValid, eHostTxValid, eHostRxReady, lb;
        bit doTxPush, doTxPop, doRxPush, doRxPop, doLb;
        logic [7:0] mv;
        lb           = lbIn;
        eProcReady   = mActive && (txQ.size() < DEPTH);
        eProcValid   = mActive && (rxQ.size() != 0);
        eHostTxValid = mActive && (txQ.size() != 0) && !lb;
        eHostRxReady = mActive && (rxQ.size() < DEPTH) && !lb;

        chk("proc_ready_out",    32'(proc_ready_out),    32'(eProcReady));
        chk("proc_valid_out",    32'(proc_valid_out),    32'(eProcValid));
        chk("host_tx_valid_out", 32'(host_tx_valid_out), 32'(eHostTxValid));
        chk("host_rx_ready_out", 32'(host_rx_ready_out), 32'(eHostRxReady));
        chk("tx_count",          32'(tx_count),          32'(txQ.size()));
        chk("rx_count",          32'(rx_count),          32'(rxQ.size()));
        chk("overflow",          32'(overflow),          32'(mOvf));
        chk("underflow",         32'(underflow),         32'(mUnf));
        if (eProcValid)   chk("proc_data_out",    32'(proc_data_out),    32'(rxQ[0]));
        if (eHostTxValid) chk("host_tx_data_out", 32'(host_tx_data_out), 32'(txQ[0]));

        if (host_tx_valid_out && host_tx_ready_in) hostGot.push_back(host_tx_data_out);
        if (proc_valid_out && proc_rden_in)        procGot.push_back(proc_data_out);
        if (lb && host_tx_valid_out)               sawHostTxValid = 1'b1;

        // Advance the model to the state after the coming rising edge.
        if (!reset) begin
          txQ.delete();
          rxQ.delete();
          mOvf    = 1'b0;
          mUnf    = 1'b0;
          mActive = 1'b0;
        end else begin
          doTxPush = proc_wren_in && eProcReady;
          doTxPop  = eHostTxValid && host_tx_ready_in;
          doRxPush = host_rx_valid_in && eHostRxReady;
          doRxPop  = proc_rden_in && eProcValid;
          doLb     = lb && mActive && (txQ.size() != 0) && (rxQ.size() < DEPTH);
          if (proc_wren_in && txQ.size() == DEPTH) mOvf = 1'b1;
          if (proc_rden_in && rxQ.size() == 0)     mUnf = 1'b1;
          if (doRxPop) void'(rxQ.pop_front());
          if (doLb) begin
            mv = txQ.pop_front();
            rxQ.push_back(mv);
          end
          if (doTxPop)  void'(txQ.pop_front());
          if (doTxPush) txQ.push_back(proc_data_in);
          if (doRxPush) rxQ.push_back(host_rx_data_in);
          mActive = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp3 [3];
    exp3 = '{8'h41, 8'h42, 8'h43};

    reset            = 1'b0;
    proc_data_in     = 8'h00;
    proc_rden_in     = 1'b0;
    proc_wren_in     = 1'b0;
    host_rx_data_in  = 8'h00;
    host_rx_valid_in = 1'b0;
    host_tx_ready_in = 1'b0;
    lbIn             = 1'b0;

    // Reset held for two edges, then released.
    tick();
    tick();
    chk("rst_held_proc_ready", 32'(proc_ready_out), 32'(0));
    chk("rst_held_host_ready", 32'(host_rx_ready_out), 32'(0));
    reset = 1'b1;
    tick();
    chk("rst_proc_ready",  32'(proc_ready_out),    32'(1));
    chk("rst_host_ready",  32'(host_rx_ready_out), 32'(1));
    chk("rst_proc_valid",  32'(proc_valid_out),    32'(0));
    chk("rst_host_valid",  32'(host_tx_valid_out), 32'(0));
    chk("rst_counts",      32'({tx_count, rx_count}), 32'(0));
    chk("rst_flags",       32'({overflow, underflow}), 32'(0));

    // Processor write path.
    for (int i = 0; i < 3; i++) begin
      proc_data_in = exp3[i];
      proc_wren_in = 1'b1;
      tick();
    end
    proc_wren_in = 1'b0;
    chk("wr_tx_count",    32'(tx_count),   32'(3));
    chk("wr_model_count", 32'(txQ.size()), 32'(3));
    hostGot.delete();
    host_tx_ready_in = 1'b1;
    repeat (6) tick();
    host_tx_ready_in = 1'b0;
    chk("wr_host_len", 32'(hostGot.size()), 32'(3));
    for (int i = 0; i < 3; i++)
      chk("wr_host_byte", (i < hostGot.size()) ? 32'(hostGot[i]) : 32'hFFFF_FFFF, 32'(exp3[i]));
    chk("wr_tx_drained", 32'(tx_count), 32'(0));

    // Processor read path.
    host_rx_data_in  = 8'h55;
    host_rx_valid_in = 1'b1;
    tick();
    host_rx_valid_in = 1'b0;
    chk("rd_valid", 32'(proc_valid_out), 32'(1));
    chk("rd_data",  32'(proc_data_out),  32'(8'h55));
    proc_rden_in = 1'b1;
    tick();
    proc_rden_in = 1'b0;
    chk("rd_valid_after_pop", 32'(proc_valid_out), 32'(0));
    chk("rd_rx_count",        32'(rx_count),       32'(0));
    chk("rd_no_underflow",    32'(underflow),      32'(0));

    // TX full, overflow, drain.
    for (int i = 0; i < 16; i++) begin
      proc_data_in = 8'(i);
      proc_wren_in = 1'b1;
      tick();
    end
    proc_data_in = 8'hFF;
    tick();
    proc_wren_in = 1'b0;
    chk("full_proc_ready", 32'(proc_ready_out), 32'(0));
    chk("full_tx_count",   32'(tx_count),       32'(16));
    chk("full_overflow",   32'(overflow),       32'(1));
    hostGot.delete();
    host_tx_ready_in = 1'b1;
    repeat (20) tick();
    host_tx_ready_in = 1'b0;
    chk("full_drain_len", 32'(hostGot.size()), 32'(16));
    for (int i = 0; i < 16; i++)
      chk("full_drain_byte", (i < hostGot.size()) ? 32'(hostGot[i]) : 32'hFFFF_FFFF, 32'(i));
    chk("full_tx_empty", 32'(tx_count), 32'(0));
    chk("full_overflow_sticky", 32'(overflow), 32'(1));

    // Underflow, then a 40-byte stream across pointer wrap.
    proc_rden_in = 1'b1;
    tick();
    proc_rden_in = 1'b0;
    chk("unf_flag",     32'(underflow), 32'(1));
    chk("unf_rx_count", 32'(rx_count),  32'(0));
    procGot.delete();
    for (int i = 0; i < 40; i++) begin
      host_rx_data_in  = 8'(8'h80 + i);
      host_rx_valid_in = 1'b1;
      proc_rden_in     = (i % 3) != 0;
      tick();
    end
    host_rx_valid_in = 1'b0;
    proc_rden_in     = 1'b1;
    repeat (20) tick();
    proc_rden_in = 1'b0;
    chk("wrap_len", 32'(procGot.size()), 32'(40));
    for (int i = 0; i < 40; i++)
      chk("wrap_byte", (i < procGot.size()) ? 32'(procGot[i]) : 32'hFFFF_FFFF, 32'(8'h80 + i));
    chk("wrap_rx_empty", 32'(rx_count), 32'(0));

    // RX full with simultaneous push and pop: push refused, count drops.
    procGot.delete();
    for (int i = 0; i < 16; i++) begin
      host_rx_data_in  = 8'(8'h10 + i);
      host_rx_valid_in = 1'b1;
      tick();
    end
    chk("rxfull_ready", 32'(host_rx_ready_out), 32'(0));
    host_rx_data_in = 8'hEE;
    proc_rden_in    = 1'b1;
    tick();
    host_rx_valid_in = 1'b0;
    chk("rxfull_pop_count", 32'(rx_count), 32'(15));
    repeat (20) tick();
    proc_rden_in = 1'b0;
    chk("rxfull_len", 32'(procGot.size()), 32'(16));
    for (int i = 0; i < 16; i++)
      chk("rxfull_byte", (i < procGot.size()) ? 32'(procGot[i]) : 32'hFFFF_FFFF, 32'(8'h10 + i));

    // RX empty with simultaneous push and pop: pop refused, count grows.
    host_rx_data_in  = 8'h77;
    host_rx_valid_in = 1'b1;
    proc_rden_in     = 1'b1;
    tick();
    host_rx_valid_in = 1'b0;
    proc_rden_in     = 1'b0;
    chk("rxempty_count", 32'(rx_count),      32'(1));
    chk("rxempty_data",  32'(proc_data_out), 32'(8'h77));
    proc_rden_in = 1'b1;
    tick();
    proc_rden_in = 1'b0;

`ifdef SERIAL_LOOPBACK_EN
    // Loopback: processor writes come back on the read side only.
    lbIn             = 1'b1;
    host_tx_ready_in = 1'b1;
    host_rx_data_in  = 8'hC3;
    host_rx_valid_in = 1'b1;
    sawHostTxValid   = 1'b0;
    procGot.delete();
    proc_data_in = 8'h5A;
    proc_wren_in = 1'b1;
    tick();
    proc_data_in = 8'hA5;
    tick();
    proc_wren_in = 1'b0;
    tick();
    tick();
    chk("lb_proc_valid", 32'(proc_valid_out), 32'(1));
    chk("lb_rx_count",   32'(rx_count),       32'(2));
    proc_rden_in = 1'b1;
    repeat (3) tick();
    proc_rden_in = 1'b0;
    chk("lb_len", 32'(procGot.size()), 32'(2));
    chk("lb_byte0", (procGot.size() > 0) ? 32'(procGot[0]) : 32'hFFFF_FFFF, 32'(8'h5A));
    chk("lb_byte1", (procGot.size() > 1) ? 32'(procGot[1]) : 32'hFFFF_FFFF, 32'(8'hA5));
    chk("lb_host_tx_quiet", 32'(sawHostTxValid), 32'(0));
    lbIn             = 1'b0;
    host_tx_ready_in = 1'b0;
    host_rx_valid_in = 1'b0;
    tick();
`endif

    // Reset mid-transfer discards buffered bytes and clears the flags.
    host_tx_ready_in = 1'b0;
    proc_data_in     = 8'h11;
    proc_wren_in     = 1'b1;
    tick();
    proc_data_in = 8'h22;
    tick();
    proc_wren_in = 1'b0;
    chk("mid_tx_count", 32'(tx_count), 32'(2));
    reset = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(host_tx_valid_out), 32'(0));
    reset = 1'b1;
    tick();
    chk("mid_tx_cleared",  32'(tx_count),          32'(0));
    chk("mid_host_valid",  32'(host_tx_valid_out), 32'(0));
    chk("mid_flags",       32'({overflow, underflow}), 32'(0));
    chk("mid_proc_ready",  32'(proc_ready_out),    32'(1));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
